// File: rtl/alu_pkg.sv
// Shared types for the ALU share scheduler: ALU opcodes, scheduler states
// and the registered operand bundle.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             cin;
        alu_op_e          op;
    } alu_req_t;

    function automatic alu_op_e to_op(input logic [1:0] ctrl);
        return alu_op_e'(ctrl);
    endfunction

endpackage

// File: rtl/alu_share_scheduler_alu.sv
// Single 32-bit ALU datapath (add/sub/and/or) shared by all requesters.
module ThirtyTwo_Bit_ALU
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  alu_op_e      op,
    output logic [W-1:0] y,
    output logic         cout
);

    logic [W:0]   sum;
    logic [W-1:0] b_eff;

    // Subtract is a + ~b + cin, so cout is the carry (NOT borrow).
    assign b_eff = (op == ALU_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                y    = sum[W-1:0];
                cout = sum[W];
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (en && !found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_scheduler.sv
// Time-shares one ThirtyTwo_Bit_ALU among NREQ requesters with round-robin
// grant, registered operands and a registered, back-pressurable result.
module alu_share_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ*2-1:0] req_ctrl,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [IDW-1:0]  resp_id,
    output logic [W-1:0]    resp_data,
    output logic            resp_cout,
    output logic            busy
);

    sched_state_e   state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] op_id;
    logic [NREQ-1:0] gnt;
    logic           arb_en;
    logic           hs;
    alu_req_t       op_d;
    alu_req_t       op_q;
    logic [W-1:0]   alu_y;
    logic           alu_co;

    // A new grant is possible when idle, or in RESP in the same cycle the
    // consumer takes the result (back-to-back issue).
    assign arb_en = (state == S_IDLE) || ((state == S_RESP) && resp_ready);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;
    assign ptr_nxt   = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

    always_comb begin
        op_d.a   = req_a[int'(gidx)*W +: W];
        op_d.b   = req_b[int'(gidx)*W +: W];
        op_d.cin = req_cin[gidx];
        op_d.op  = to_op(req_ctrl[int'(gidx)*2 +: 2]);
    end

    ThirtyTwo_Bit_ALU #(.W(W)) u_alu (
        .a    (op_q.a),
        .b    (op_q.b),
        .cin  (op_q.cin),
        .op   (op_q.op),
        .y    (alu_y),
        .cout (alu_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            op_id     <= '0;
            op_q      <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_cout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        op_q  <= op_d;
                        op_id <= gidx;
                        ptr   <= ptr_nxt;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_data <= alu_y;
                    resp_cout <= alu_co;
                    resp_id   <= op_id;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        if (hs) begin
                            op_q  <= op_d;
                            op_id <= gidx;
                            ptr   <= ptr_nxt;
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);

endmodule
